// File: rtl/level_mode_ctrl.sv
// level_mode_ctrl
// Mode controller and sample scheduler for the level finder.
//   - Synchronizes and debounces the manual/automatic toggle switch and
//     drives the mode LED.
//   - Issues sample requests to the accelerometer reader: periodically in
//     automatic mode, one per manual_step pulse in manual mode.
//   - Pulses display_load once the reader acknowledges a captured sample.
//   - Flags a sticky timeout error when a request goes unacknowledged.
//
// Ports:
//   clk           in   system clock, all logic on posedge
//   reset         in   asynchronous, active-high reset
//   toggle_in     in   raw switch (async to clk); 1 = manual, 0 = automatic
//   manual_step   in   one-cycle debounced pulse; one sample in manual mode
//   sample_ack    in   one-cycle pulse when the requested sample is captured
//   sample_req    out  level request to the reader
//   display_load  out  one-cycle pulse loading the new reading
//   manual_mode   out  debounced mode; 1 = manual
//   LED1          out  registered copy of manual_mode
//   timeout_err   out  sticky: a request expired without an ack
module level_mode_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned SAMPLE_PERIOD   = 5000000,
    parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic toggle_in,
    input  logic manual_step,
    input  logic sample_ack,
    output logic sample_req,
    output logic display_load,
    output logic manual_mode,
    output logic LED1,
    output logic timeout_err
);

    localparam int unsigned DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int unsigned PER_W = (SAMPLE_PERIOD   > 1) ? $clog2(SAMPLE_PERIOD)   : 1;
    localparam int unsigned TO_W  = (TIMEOUT_CYCLES  > 1) ? $clog2(TIMEOUT_CYCLES)  : 1;

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(SAMPLE_PERIOD - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_REQ  = 2'd1,
        ST_LOAD = 2'd2
    } state_t;

    logic             sync_meta;
    logic             sync;
    logic             stable;
    logic [DB_W-1:0]  db_cnt;
    logic             mode_flip_c;

    state_t           state;
    state_t           state_d;
    logic [PER_W-1:0] per_cnt;
    logic [PER_W-1:0] per_cnt_d;
    logic [TO_W-1:0]  to_cnt;
    logic [TO_W-1:0]  to_cnt_d;
    logic             timeout_err_d;

    // Two-flop synchronizer for the raw switch
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta <= 1'b0;
            sync      <= 1'b0;
        end else begin
            sync_meta <= toggle_in;
            sync      <= sync_meta;
        end
    end

    // The stable mode flips on this cycle's edge
    assign mode_flip_c = (sync != stable) && (db_cnt == DB_LAST);

    // Debounce: any return to the stable value restarts the window
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable <= 1'b0;
            db_cnt <= '0;
        end else if (sync == stable) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_LAST) begin
            stable <= sync;
            db_cnt <= '0;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

    // Mode outputs; LED1 trails manual_mode by one cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            manual_mode <= 1'b0;
            LED1        <= 1'b0;
        end else begin
            manual_mode <= mode_flip_c ? sync : stable;
            LED1        <= manual_mode;
        end
    end

    // Scheduler next-state logic
    always_comb begin
        state_d       = state;
        per_cnt_d     = per_cnt;
        to_cnt_d      = '0;
        timeout_err_d = timeout_err;

        case (state)
            ST_WAIT: begin
                if (mode_flip_c) begin
                    // A mode change restarts scheduling from a clean WAIT
                    per_cnt_d = '0;
                end else if (stable) begin
                    per_cnt_d = '0;
                    if (manual_step) begin
                        state_d = ST_REQ;
                    end
                end else if (per_cnt == PER_LAST) begin
                    per_cnt_d = '0;
                    state_d   = ST_REQ;
                end else begin
                    per_cnt_d = per_cnt + PER_W'(1);
                end
            end
            ST_REQ: begin
                if (sample_ack) begin
                    // Ack beats a coincident timeout
                    state_d = ST_LOAD;
                end else if (to_cnt == TO_LAST) begin
                    state_d = ST_WAIT;
                end else begin
                    to_cnt_d = to_cnt + TO_W'(1);
                end
            end
            ST_LOAD: begin
                state_d = ST_WAIT;
            end
            default: begin
                state_d = ST_WAIT;
            end
        endcase

        if (mode_flip_c) begin
            per_cnt_d     = '0;
            timeout_err_d = 1'b0;
        end

        // A fresh expiry still reports even if the mode flips on that edge
        if ((state == ST_REQ) && !sample_ack && (to_cnt == TO_LAST)) begin
            timeout_err_d = 1'b1;
        end
    end

    // Scheduler state and state-decoded registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_WAIT;
            per_cnt      <= '0;
            to_cnt       <= '0;
            timeout_err  <= 1'b0;
            sample_req   <= 1'b0;
            display_load <= 1'b0;
        end else begin
            state        <= state_d;
            per_cnt      <= per_cnt_d;
            to_cnt       <= to_cnt_d;
            timeout_err  <= timeout_err_d;
            sample_req   <= (state_d == ST_REQ);
            display_load <= (state_d == ST_LOAD);
        end
    end

endmodule

// File: tb/tb_level_mode_ctrl.sv
// Directed bench for level_mode_ctrl with DEBOUNCE_CYCLES=4,
// SAMPLE_PERIOD=10, TIMEOUT_CYCLES=5. Cycle k is the interval after the
// k-th rising edge following reset release; outputs are sampled and inputs
// driven on the falling edge inside that interval.
module tb_level_mode_ctrl;

    logic clk;
    logic reset;
    logic toggle_in;
    logic manual_step;
    logic sample_ack;
    logic sample_req;
    logic display_load;
    logic manual_mode;
    logic LED1;
    logic timeout_err;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    level_mode_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .SAMPLE_PERIOD  (10),
        .TIMEOUT_CYCLES (5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .toggle_in   (toggle_in),
        .manual_step (manual_step),
        .sample_ack  (sample_ack),
        .sample_req  (sample_req),
        .display_load(display_load),
        .manual_mode (manual_mode),
        .LED1        (LED1),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"},  32'(sample_req),   32'd0);
        chk({tag, "_load"}, 32'(display_load), 32'd0);
        chk({tag, "_mode"}, 32'(manual_mode),  32'd0);
        chk({tag, "_led"},  32'(LED1),         32'd0);
        chk({tag, "_err"},  32'(timeout_err),  32'd0);
    endtask

    initial begin
        int req_seen;
        int loads;
        int reqs;

        reset       = 1'b1;
        toggle_in   = 1'b0;
        manual_step = 1'b0;
        sample_ack  = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("rst");

        // Automatic schedule, ack two cycles after each request
        reset = 1'b0;
        cyc   = 0;
        run_to(9);  chk("auto_req_c9",  32'(sample_req), 32'd0);
        run_to(10); chk("auto_req_c10", 32'(sample_req), 32'd1);
        run_to(12); sample_ack = 1'b1;
        run_to(13); sample_ack = 1'b0;
        chk("auto_load_c13", 32'(display_load), 32'd1);
        chk("auto_req_c13",  32'(sample_req),   32'd0);
        run_to(14); chk("auto_load_c14", 32'(display_load), 32'd0);
        run_to(23); chk("auto_req_c23",  32'(sample_req),   32'd0);
        run_to(24); chk("auto_req_c24",  32'(sample_req),   32'd1);

        // Ack on the final timeout cycle: ack wins
        run_to(28); chk("coinc_req_c28", 32'(sample_req), 32'd1);
        sample_ack = 1'b1;
        run_to(29); sample_ack = 1'b0;
        chk("coinc_load", 32'(display_load), 32'd1);
        chk("coinc_err",  32'(timeout_err),  32'd0);
        chk("coinc_req",  32'(sample_req),   32'd0);

        // No ack: request high for exactly 5 cycles, then sticky error
        run_to(39); chk("to_req_c39", 32'(sample_req),  32'd0);
        run_to(40); chk("to_req_c40", 32'(sample_req),  32'd1);
        run_to(44); chk("to_req_c44", 32'(sample_req),  32'd1);
        chk("to_err_c44", 32'(timeout_err), 32'd0);
        run_to(45); chk("to_req_c45", 32'(sample_req),  32'd0);
        chk("to_err_c45", 32'(timeout_err), 32'd1);

        // manual_step has no effect in automatic mode
        manual_step = 1'b1;
        run_to(46); manual_step = 1'b0;
        chk("auto_step_ignored", 32'(sample_req), 32'd0);

        // Error persists through a good sample
        run_to(55); chk("good_req_c55", 32'(sample_req), 32'd1);
        run_to(57); sample_ack = 1'b1;
        run_to(58); sample_ack = 1'b0;
        chk("good_load_c58", 32'(display_load), 32'd1);
        chk("good_err_c58",  32'(timeout_err),  32'd1);
        run_to(60); chk("good_err_c60", 32'(timeout_err), 32'd1);

        // Three-cycle switch glitch is rejected
        toggle_in = 1'b1;
        run_to(63); toggle_in = 1'b0;
        run_to(66); chk("glitch_mode_c66", 32'(manual_mode), 32'd0);
        run_to(69); chk("glitch_mode_c69", 32'(manual_mode), 32'd0);
        chk("req5_c69", 32'(sample_req), 32'd1);

        // Held switch: mode after 6 cycles, LED after 7, error cleared
        run_to(70); toggle_in = 1'b1;
        run_to(73); chk("req5_c73", 32'(sample_req), 32'd1);
        run_to(74); chk("req5_c74", 32'(sample_req), 32'd0);
        run_to(75); chk("mode_c75", 32'(manual_mode), 32'd0);
        chk("err_c75", 32'(timeout_err), 32'd1);
        run_to(76); chk("mode_c76", 32'(manual_mode), 32'd1);
        chk("led_c76", 32'(LED1), 32'd0);
        chk("err_c76", 32'(timeout_err), 32'd0);
        run_to(77); chk("led_c77", 32'(LED1), 32'd1);

        // Manual mode: no periodic requests for 50 cycles
        req_seen = 0;
        while (cyc < 126) begin
            tick();
            if (sample_req) req_seen++;
        end
        chk("manual_no_periodic", 32'(req_seen), 32'd0);

        // One step, a second step during REQ is dropped
        manual_step = 1'b1;
        run_to(127); manual_step = 1'b0;
        chk("manual_req_c127", 32'(sample_req), 32'd1);
        run_to(128); manual_step = 1'b1;
        run_to(129); manual_step = 1'b0;
        run_to(130); sample_ack = 1'b1;
        run_to(131); sample_ack = 1'b0;
        chk("manual_load_c131", 32'(display_load), 32'd1);
        loads = 0;
        reqs  = 0;
        while (cyc < 160) begin
            tick();
            if (display_load) loads++;
            if (sample_req)   reqs++;
        end
        chk("manual_extra_loads", 32'(loads), 32'd0);
        chk("manual_extra_reqs",  32'(reqs),  32'd0);

        // Reset in the middle of a request clears everything at once
        manual_step = 1'b1;
        run_to(161); manual_step = 1'b0;
        chk("pre_rst_req",  32'(sample_req),  32'd1);
        chk("pre_rst_mode", 32'(manual_mode), 32'd1);
        #2;
        reset     = 1'b1;
        toggle_in = 1'b0;
        #1;
        chk_all_zero("async_rst");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cyc   = 0;
        run_to(9);  chk("rerun_req_c9",   32'(sample_req),  32'd0);
        chk("rerun_mode_c9", 32'(manual_mode), 32'd0);
        run_to(10); chk("rerun_req_c10",  32'(sample_req),  32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/level_mode_ctrl.md
# level_mode_ctrl

Mode controller and sample scheduler for the level finder. It debounces the manual/automatic toggle switch and drives the mode LED. It sequences sample requests to the accelerometer reader: periodically in automatic mode, one per button step in manual mode. It pulses a display load once each sample has been captured.

## Interface
- DEBOUNCE_CYCLES, 50000: cycles the synchronized switch must hold a new value before the mode changes (1 ms at 50 MHz).
- SAMPLE_PERIOD, 5000000: cycles between automatic sample requests (100 ms at 50 MHz).
- TIMEOUT_CYCLES, 1000: maximum cycles to wait for sample_ack.
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- toggle_in  in  1  raw switch, asynchronous to clk; 1 = manual, 0 = automatic.
- manual_step  in  1  one-cycle pulse, already debounced; requests one sample in manual mode.
- sample_ack  in  1  one-cycle pulse from the reader when the requested sample is captured.
- sample_req  out  1  level request to the reader.
- display_load  out  1  one-cycle pulse that loads the new reading into the display.
- manual_mode  out  1  debounced mode; 1 = manual.
- LED1  out  1  registered copy of manual_mode.
- timeout_err  out  1  sticky flag: a request expired without an ack.

## Operation
- Reset values:
  - Every output is 0.
  - FSM is in WAIT.
  - Sync flops, debounce, period and timeout counters are 0.
  - Stable mode is automatic.
- Synchronizer: two flops on toggle_in, giving sync.
- Debounce:
  - While sync == stable, the debounce counter is 0.
  - While sync != stable, the counter increments each cycle.
  - When the counter reaches DEBOUNCE_CYCLES-1, stable <= sync and the counter clears.
  - A glitch shorter than the window returns the counter to 0 and causes no mode change.
- manual_mode = stable. LED1 <= manual_mode, one cycle later.
- Counter widths: $clog2 of each parameter, minimum 1 bit.
- FSM states:
  - WAIT:
    - Automatic mode: the period counter increments. At SAMPLE_PERIOD-1 the counter clears and the FSM goes to REQ.
    - Manual mode: the period counter is held at 0, and manual_step goes to REQ.
    - manual_step is ignored in automatic mode.
  - REQ:
    - sample_req = 1, and the timeout counter increments.
    - sample_ack goes to LOAD.
    - At TIMEOUT_CYCLES-1 with no ack, timeout_err is set and the FSM returns to WAIT.
    - The timeout counter clears on leaving REQ.
  - LOAD: display_load = 1 for exactly one cycle, then WAIT.
- Boundary rules:
  - Ack and timeout in the same cycle: ack wins (LOAD, no error).
  - sample_ack in WAIT or LOAD is ignored.
  - manual_step in REQ or LOAD is ignored and not queued.
  - Mode change (stable toggles):
    - The period counter clears and timeout_err clears.
    - An in-progress REQ or LOAD completes normally; no handshake is aborted.
    - A change to automatic mode starts a full SAMPLE_PERIOD count from WAIT.
  - timeout_err stays set through later successful samples. Only reset or a mode change clears it.
  - Reset mid-request drops sample_req asynchronously.

## Timing
- sample_req, display_load, manual_mode and timeout_err are registered state-decoded outputs; there is no combinational path from any input.
- Mode latency: toggle_in change to manual_mode change is 2 + DEBOUNCE_CYCLES cycles, with the input held stable. LED1 follows one cycle later.
- Automatic schedule:
  - First sample_req rises SAMPLE_PERIOD cycles after reset release.
  - Next request: SAMPLE_PERIOD cycles after the FSM re-enters WAIT.
- Manual: manual_step in cycle N gives sample_req high from cycle N+1.
- Ack: sample_ack in cycle N gives sample_req low and display_load high in cycle N+1, and WAIT in cycle N+2.
- Timeout: sample_req is high for exactly TIMEOUT_CYCLES cycles. timeout_err rises the same cycle sample_req falls.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, SAMPLE_PERIOD=10, TIMEOUT_CYCLES=5.
- Reset, toggle_in=0, reader acks 2 cycles after each req:
  - Required: sample_req rises at cycle 10 after reset release.
  - Required: display_load pulses at cycle 13.
  - Required: next req at cycle 24.
- Switch glitch: toggle_in=1 for 3 cycles, then 0 → manual_mode stays 0. Then toggle_in=1 held → manual_mode=1 at 6 cycles, LED1=1 at 7 cycles.
- Manual mode, manual_step pulse: sample_req high the next cycle, no periodic requests for 50 cycles. A second manual_step during REQ is ignored (exactly one display_load).
- No ack in REQ: sample_req high for 5 cycles, then low with timeout_err=1. timeout_err persists through a later good sample and clears on toggle to manual.
- sample_ack coincident with the timeout cycle: display_load=1 and timeout_err=0.
- Assert reset while sample_req=1 → all outputs 0 immediately. After release, automatic mode and first req at cycle 10.
